// File: rtl/pkt_capture_ctrl_if.sv
// 32-bit Avalon-ST frame stream carried into pkt_capture_ctrl.
interface pkt_capture_ctrl_if;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_sop;
  logic        st_eop;
  logic [1:0]  st_empty;
  logic        st_ready;

  modport master (output st_data, st_valid, st_sop, st_eop, st_empty, input st_ready);
  modport slave  (input st_data, st_valid, st_sop, st_eop, st_empty, output st_ready);
endinterface

// File: rtl/pkt_capture_ctrl.sv
// Frame capture front-end: stream -> packet FIFO, descriptor hand-off to the write controller.
// Optional truncation counter output trunc_cnt is built when PKT_TRUNC_CNT_EN is defined.
module pkt_capture_ctrl #(
  parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
  parameter logic [31:0] BUF_SIZE      = 32'h0010_0000,
  parameter int          MAX_PKT_BYTES = 1536,
  parameter int          FIFO_DEPTH    = 512
) (
  input  logic               clk,
  input  logic               reset,
  pkt_capture_ctrl_if.slave  st,
  output logic               fifo_wrreq,
  output logic [31:0]        fifo_data,
  input  logic [8:0]         fifo_usedw,
  input  logic [31:0]        seconds,
  input  logic [31:0]        nanoseconds,
  output logic               wr_ctrl,
  input  logic               wr_ctrl_rdy,
  output logic [31:0]        control,
  output logic [31:0]        pkt_begin,
  output logic [31:0]        pkt_end,
  output logic [31:0]        write_address,
  output logic [31:0]        ts_seconds,
  output logic [31:0]        ts_nanoseconds
`ifdef PKT_TRUNC_CNT_EN
  ,
  output logic [15:0]        trunc_cnt
`endif
);

  localparam logic [16:0] MAX_BEATS   = 17'(MAX_PKT_BYTES / 4);
  localparam logic [18:0] MAX_BYTES   = 19'(MAX_PKT_BYTES);
  localparam logic [9:0]  USEDW_LIMIT = 10'(FIFO_DEPTH - 2);
  localparam logic [32:0] RING_END    = {1'b0, BUF_BASE} + {1'b0, BUF_SIZE};
  localparam logic [32:0] REC_RESERVE = 33'(16 + MAX_PKT_BYTES);

  typedef enum logic [2:0] {IDLE, CAPTURE, SKIP, ISSUE, WAIT_RDY} state_t;

  state_t      state_r, state_nxt_s;
  logic [16:0] beat_cnt_r, cnt_nxt_s, cnt_inc_s, issue_beats_s;
  logic        trunc_r, trunc_nxt_s;
  logic [31:0] next_addr_r;
  logic [1:0]  issue_empty_s;
  logic        room_s, ready_s, accept_s;
  logic        wrreq_s, ts_latch_s, issue_s, adv_s;
  logic [18:0] orig_s, end_len_s;
  logic [15:0] ctrl_len_s;
  logic [31:0] rec_s, cand_s;
  logic        wrap_s;

  // Two words of headroom keep the FIFO from ever being written at its high-water mark.
  assign room_s      = {1'b0, fifo_usedw} < USEDW_LIMIT;
  assign ready_s     = reset & (((state_r == IDLE) || (state_r == CAPTURE)) ? room_s : (state_r == SKIP));
  assign st.st_ready = ready_s;
  assign accept_s    = st.st_valid & ready_s;
  assign cnt_inc_s   = (beat_cnt_r == 17'h1_FFFF) ? beat_cnt_r : beat_cnt_r + 17'd1;

  assign fifo_wrreq  = wrreq_s;
  assign fifo_data   = wrreq_s ? st.st_data : 32'h0000_0000;
  assign wr_ctrl     = (state_r == ISSUE);
  assign pkt_begin   = 32'h0000_0000;

  assign orig_s      = {issue_beats_s, 2'b00} - {17'b0, issue_empty_s};
  assign ctrl_len_s  = (orig_s > 19'h0_FFFF) ? 16'hFFFF : orig_s[15:0];
  assign end_len_s   = (orig_s > MAX_BYTES) ? MAX_BYTES : orig_s;

  // Record footprint is a 16-byte header plus payload rounded up to 16 bytes.
  assign rec_s  = 32'd16 + ((pkt_end + 32'd15) & ~32'd15);
  assign cand_s = next_addr_r + rec_s;
  assign wrap_s = ({1'b0, cand_s} + REC_RESERVE) > RING_END;

  // Next-state and per-beat strobes.
  always_comb begin
    state_nxt_s   = state_r;
    wrreq_s       = 1'b0;
    ts_latch_s    = 1'b0;
    issue_s       = 1'b0;
    adv_s         = 1'b0;
    cnt_nxt_s     = beat_cnt_r;
    trunc_nxt_s   = trunc_r;
    issue_beats_s = cnt_inc_s;
    issue_empty_s = st.st_empty;
    case (state_r)
      IDLE: begin
        if (accept_s && st.st_sop) begin
          wrreq_s       = 1'b1;
          ts_latch_s    = 1'b1;
          cnt_nxt_s     = 17'd1;
          trunc_nxt_s   = 1'b0;
          issue_beats_s = 17'd1;
          if (st.st_eop) begin
            issue_s     = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = CAPTURE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CAPTURE: begin
        if (accept_s && st.st_sop) begin
          // A new sop closes the running frame; the sop word itself is dropped.
          issue_s       = 1'b1;
          issue_beats_s = beat_cnt_r;
          issue_empty_s = 2'b00;
          state_nxt_s   = ISSUE;
        end else if (accept_s) begin
          wrreq_s   = 1'b1;
          cnt_nxt_s = cnt_inc_s;
          if (st.st_eop) begin
            issue_s     = 1'b1;
            state_nxt_s = ISSUE;
          end else if (cnt_inc_s == MAX_BEATS) begin
            trunc_nxt_s = 1'b1;
            state_nxt_s = SKIP;
          end else begin
            state_nxt_s = CAPTURE;
          end
        end else begin
          state_nxt_s = CAPTURE;
        end
      end
      SKIP: begin
        if (accept_s) begin
          cnt_nxt_s = cnt_inc_s;
          if (st.st_eop) begin
            issue_s     = 1'b1;
            state_nxt_s = ISSUE;
          end else begin
            state_nxt_s = SKIP;
          end
        end else begin
          state_nxt_s = SKIP;
        end
      end
      ISSUE: state_nxt_s = WAIT_RDY;
      WAIT_RDY: begin
        if (wr_ctrl_rdy) begin
          adv_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_RDY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state, beat counter and truncation flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      beat_cnt_r <= 17'd0;
      trunc_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= cnt_nxt_s;
      trunc_r    <= trunc_nxt_s;
    end
  end

  // Timestamp and descriptor registers; descriptor holds until the next frame is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_seconds     <= 32'h0000_0000;
      ts_nanoseconds <= 32'h0000_0000;
      control        <= 32'h0000_0000;
      pkt_end        <= 32'h0000_0000;
      write_address  <= 32'h0000_0000;
    end else begin
      if (ts_latch_s) begin
        ts_seconds     <= seconds;
        ts_nanoseconds <= nanoseconds;
      end
      if (issue_s) begin
        control       <= {trunc_nxt_s, 15'b0, ctrl_len_s};
        pkt_end       <= {13'b0, end_len_s};
        write_address <= next_addr_r;
      end
    end
  end

  // Ring write pointer advances once the write controller reports completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_addr_r <= BUF_BASE;
    end else if (adv_s) begin
      next_addr_r <= wrap_s ? BUF_BASE : cand_s;
    end
  end

`ifdef PKT_TRUNC_CNT_EN
  logic trunc_evt_s;
  assign trunc_evt_s = accept_s && (state_r == CAPTURE) &&
                       (st.st_sop || (!st.st_eop && (cnt_inc_s == MAX_BEATS)));

  // Saturating count of frames cut short by snap length or by an early sop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trunc_cnt <= 16'h0000;
    end else if (trunc_evt_s && (trunc_cnt != 16'hFFFF)) begin
      trunc_cnt <= trunc_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_capture_ctrl.sv
// Directed bench for pkt_capture_ctrl (ring of 4 KiB at 0x0001_0000 to exercise wrap).
module tb_pkt_capture_ctrl;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int SNAP_BEATS = 384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic [8:0]  fifo_usedw = 9'd0;
  logic [31:0] seconds = 32'd0, nanoseconds = 32'd0;
  logic        wr_ctrl;
  logic        wr_ctrl_rdy = 1'b0;
  logic [31:0] control, pkt_begin, pkt_end, write_address, ts_seconds, ts_nanoseconds;
`ifdef PKT_TRUNC_CNT_EN
  logic [15:0] trunc_cnt;
`endif

  int total = 0;
  int bad = 0;
  int bad_writes = 0;
  int pulses = 0;
  logic [31:0] wq[$];
  logic [31:0] expq[$];

  pkt_capture_ctrl_if st_if ();

  pkt_capture_ctrl #(.BUF_BASE(BASE), .BUF_SIZE(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .st(st_if),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_usedw(fifo_usedw),
    .seconds(seconds), .nanoseconds(nanoseconds),
    .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy),
    .control(control), .pkt_begin(pkt_begin), .pkt_end(pkt_end),
    .write_address(write_address), .ts_seconds(ts_seconds), .ts_nanoseconds(ts_nanoseconds)
`ifdef PKT_TRUNC_CNT_EN
    , .trunc_cnt(trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_wrreq) begin
      wq.push_back(fifo_data);
      if (fifo_usedw >= 9'd510) bad_writes <= bad_writes + 1;
    end
    if (wr_ctrl) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input bit sop, input bit eop, input logic [1:0] emp,
                      output int waits);
    waits = 0;
    @(negedge clk);
    st_if.st_data = d; st_if.st_sop = sop; st_if.st_eop = eop; st_if.st_empty = emp;
    st_if.st_valid = 1'b1;
    #1;
    while (!st_if.st_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= 200) chk("beat_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    st_if.st_valid = 1'b0; st_if.st_sop = 1'b0; st_if.st_eop = 1'b0; st_if.st_empty = 2'd0;
  endtask

  task automatic send_frame(input int nbytes, input logic [31:0] seed,
                            input logic [31:0] sec, input logic [31:0] nsec, output int skip_waits);
    int beats;
    int w;
    beats = (nbytes + 3) / 4;
    skip_waits = 0;
    for (int i = 0; i < beats; i++) begin
      if (i == 0) begin seconds = sec; nanoseconds = nsec; end
      beat(seed + 32'(i), i == 0, i == beats - 1,
           (i == beats - 1) ? 2'(4 * beats - nbytes) : 2'd0, w);
      if (i == 0) begin seconds = sec + 32'd1000; nanoseconds = nsec + 32'd1000; end
      if (i < SNAP_BEATS) expq.push_back(seed + 32'(i));
      else skip_waits += w;
    end
  endtask

  task automatic check_fifo(input string tag);
    int mism;
    mism = 0;
    chk({tag, "_wrcnt"}, 32'(wq.size()), 32'(expq.size()));
    for (int i = 0; i < wq.size() && i < expq.size(); i++)
      if (wq[i] !== expq[i]) mism++;
    chk({tag, "_wrdata"}, 32'(mism), 32'd0);
    wq.delete();
    expq.delete();
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] e_end, input logic [31:0] e_ctrl,
                              input logic [31:0] e_addr);
    int g;
    g = 0;
    @(negedge clk);
    while (!wr_ctrl && g < 50) begin @(negedge clk); g++; end
    chk({tag, "_wr_ctrl"}, {31'b0, wr_ctrl}, 32'd1);
    chk({tag, "_pkt_end"}, pkt_end, e_end);
    chk({tag, "_control"}, control, e_ctrl);
    chk({tag, "_addr"}, write_address, e_addr);
    chk({tag, "_pkt_begin"}, pkt_begin, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse_1cyc"}, {31'b0, wr_ctrl}, 32'd0);
    chk({tag, "_wait_ready"}, {31'b0, st_if.st_ready}, 32'd0);
  endtask

  task automatic rdy_pulse();
    @(negedge clk);
    wr_ctrl_rdy = 1'b1;
    @(posedge clk);
    #1 wr_ctrl_rdy = 1'b0;
  endtask

  initial begin
    int sw;
    int w;
    st_if.st_data = 32'd0; st_if.st_valid = 1'b0; st_if.st_sop = 1'b0;
    st_if.st_eop = 1'b0; st_if.st_empty = 2'd0;

    // reset state
    #12;
    chk("rst_ready", {31'b0, st_if.st_ready}, 32'd0);
    chk("rst_wrreq", {31'b0, fifo_wrreq}, 32'd0);
    chk("rst_wr_ctrl", {31'b0, wr_ctrl}, 32'd0);
    chk("rst_control", control, 32'd0);
    chk("rst_addr", write_address, 32'd0);
    chk("rst_ts", ts_seconds | ts_nanoseconds | pkt_end, 32'd0);
    @(negedge clk) reset = 1'b1;
    #1 chk("idle_ready", {31'b0, st_if.st_ready}, 32'd1);

    // non-sop beat in IDLE is dropped; stray rdy pulse is ignored
    beat(32'hDEAD_0000, 1'b0, 1'b0, 2'd0, w);
    rdy_pulse();
    chk("idle_drop", 32'(wq.size()), 32'd0);

    // F1: 64 bytes
    send_frame(64, 32'hA100_0000, 32'd5, 32'd100, sw);
    expect_issue("f1", 32'd64, 32'd64, BASE);
    chk("f1_ts_s", ts_seconds, 32'd5);
    chk("f1_ts_ns", ts_nanoseconds, 32'd100);
    check_fifo("f1");
    // second frame arrives before wr_ctrl_rdy
    @(negedge clk);
    st_if.st_data = 32'hBEEF_0000; st_if.st_sop = 1'b1; st_if.st_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold_ready", {31'b0, st_if.st_ready}, 32'd0);
      chk("hold_wrreq", {31'b0, fifo_wrreq}, 32'd0);
      @(negedge clk);
    end
    st_if.st_valid = 1'b0; st_if.st_sop = 1'b0;
    rdy_pulse();

    // F2: 61 bytes
    send_frame(61, 32'hA200_0000, 32'd6, 32'd200, sw);
    expect_issue("f2", 32'd61, 32'd61, BASE + 32'd80);
    check_fifo("f2");
    rdy_pulse();

    // F3: 2000 bytes, truncated at snap length
    send_frame(2000, 32'hA300_0000, 32'd7, 32'd300, sw);
    chk("f3_skip_ready", 32'(sw), 32'd0);
    expect_issue("f3", 32'd1536, 32'h8000_07D0, BASE + 32'd160);
    check_fifo("f3");
`ifdef PKT_TRUNC_CNT_EN
    chk("f3_trunc_cnt", {16'b0, trunc_cnt}, 32'd1);
`endif
    rdy_pulse();

    // F4: 32 bytes with FIFO backpressure mid-frame
    seconds = 32'd8;
    beat(32'hA400_0000, 1'b1, 1'b0, 2'd0, w);
    beat(32'hA400_0001, 1'b0, 1'b0, 2'd0, w);
    for (int i = 0; i < 2; i++) expq.push_back(32'hA400_0000 + 32'(i));
    @(negedge clk);
    fifo_usedw = 9'd509;
    #1 chk("bp_509_ready", {31'b0, st_if.st_ready}, 32'd1);
    fifo_usedw = 9'd510;
    st_if.st_data = 32'hA400_0002; st_if.st_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", {31'b0, st_if.st_ready}, 32'd0);
      chk("bp_wrreq", {31'b0, fifo_wrreq}, 32'd0);
      @(negedge clk);
    end
    st_if.st_valid = 1'b0;
    fifo_usedw = 9'd100;
    for (int i = 2; i < 8; i++) begin
      beat(32'hA400_0000 + 32'(i), 1'b0, i == 7, 2'd0, w);
      expq.push_back(32'hA400_0000 + 32'(i));
    end
    expect_issue("f4", 32'd32, 32'd32, BASE + 32'd1712);
    check_fifo("f4");
    rdy_pulse();

    // F5: sop inside CAPTURE closes the frame after 3 beats
    for (int i = 0; i < 3; i++) begin
      beat(32'hA500_0000 + 32'(i), i == 0, 1'b0, 2'd0, w);
      expq.push_back(32'hA500_0000 + 32'(i));
    end
    beat(32'hA5FF_FFFF, 1'b1, 1'b0, 2'd3, w);
    expect_issue("f5", 32'd12, 32'd12, BASE + 32'd1760);
    check_fifo("f5");
`ifdef PKT_TRUNC_CNT_EN
    chk("f5_trunc_cnt", {16'b0, trunc_cnt}, 32'd2);
`endif
    rdy_pulse();

    // F6: 1600 bytes, its record pushes the next address past the ring end
    send_frame(1600, 32'hA600_0000, 32'd9, 32'd600, sw);
    expect_issue("f6", 32'd1536, 32'h8000_0640, BASE + 32'd1792);
    check_fifo("f6");
    rdy_pulse();

    // F7: single-beat frame lands at the wrapped address
    send_frame(4, 32'hA700_0000, 32'd10, 32'd700, sw);
    expect_issue("f7", 32'd4, 32'd4, BASE);
    chk("f7_ts_s", ts_seconds, 32'd10);
    check_fifo("f7");
    rdy_pulse();

    // F8: async reset in CAPTURE
    beat(32'hA800_0000, 1'b1, 1'b0, 2'd0, w);
    beat(32'hA800_0001, 1'b0, 1'b0, 2'd0, w);
    @(negedge clk);
    st_if.st_data = 32'hA800_0002; st_if.st_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("ar_ready", {31'b0, st_if.st_ready}, 32'd0);
    chk("ar_wrreq", {31'b0, fifo_wrreq}, 32'd0);
    chk("ar_fifo_data", fifo_data, 32'd0);
    chk("ar_control", control, 32'd0);
    chk("ar_outs", pkt_end | write_address | ts_seconds | ts_nanoseconds, 32'd0);
    @(negedge clk) st_if.st_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    chk("ar_wrcnt", 32'(wq.size()), 32'd2);
    wq.delete();

    // F9: 7 bytes after reset starts again at BUF_BASE
    send_frame(7, 32'hA900_0000, 32'd11, 32'd900, sw);
    expect_issue("f9", 32'd7, 32'd7, BASE);
    chk("f9_ts_ns", ts_nanoseconds, 32'd900);
    check_fifo("f9");
    rdy_pulse();

    chk("pulses", 32'(pulses), 32'd8);
    chk("full_writes", 32'(bad_writes), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkt_capture_ctrl.md
Name: pkt_capture_ctrl

Overview:
Capture front-end directly upstream of the packet-to-memory write controller. It accepts Ethernet frames on a 32-bit Avalon-ST sink and pushes payload words into the shared show-ahead packet FIFO. It latches a timestamp at start-of-packet and computes captured length and ring-buffer write address. It then issues a one-cycle start pulse with descriptor fields to the write controller and holds off the next frame until that controller returns its done pulse.

Parameters:
BUF_BASE, 32'h0000_0000, byte base address of capture ring in host memory
BUF_SIZE, 32'h0010_0000, ring size in bytes (multiple of 16)
MAX_PKT_BYTES, 1536, snap length; bytes beyond this are discarded
FIFO_DEPTH, 512, packet FIFO depth in 32-bit words (usedw width = 9)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
st_data  in  32  stream data, first byte in [31:24]
st_valid  in  1  stream valid
st_sop  in  1  start of packet
st_eop  in  1  end of packet
st_empty  in  2  unused bytes in eop word
st_ready  out  1  stream ready
fifo_wrreq  out  1  FIFO write strobe
fifo_data  out  32  FIFO write data
fifo_usedw  in  9  FIFO fill level
seconds  in  32  free-running time, seconds
nanoseconds  in  32  free-running time, nanoseconds
wr_ctrl  out  1  one-cycle start pulse to write controller
wr_ctrl_rdy  in  1  one-cycle done pulse from write controller
control  out  32  descriptor control word: [31] truncated, [15:0] original length
pkt_begin  out  32  always 0
pkt_end  out  32  captured byte count
write_address  out  32  record start address in ring
ts_seconds  out  32  seconds latched at sop
ts_nanoseconds  out  32  nanoseconds latched at sop

Behaviour:
- Reset: all outputs 0. State IDLE. Next record address = BUF_BASE.
- FSM states: IDLE, CAPTURE, SKIP, ISSUE, WAIT_RDY.
- Beat accept: st_valid && st_ready.
- IDLE: st_ready=1. An accepted beat without sop is dropped.
  - Accepted sop beat: latch ts_seconds/ts_nanoseconds from the same cycle, write the word, set word count = 1.
  - Accepted sop beat that is also eop: go straight to ISSUE.
  - Otherwise go to CAPTURE.
- CAPTURE: st_ready = (fifo_usedw < FIFO_DEPTH-2).
  - Each accepted beat: fifo_wrreq=1 and fifo_data=st_data in the same cycle, combinational; count += 1.
  - A sop beat inside CAPTURE terminates the current frame as if eop, with st_empty=0. The new sop beat is dropped.
  - When count reaches MAX_PKT_BYTES/4 without eop: set the truncated flag, go to SKIP.
  - eop: go to ISSUE.
- SKIP: st_ready=1, no FIFO writes, keep counting original bytes. On eop go to ISSUE.
- Length arithmetic (16-bit):
  - orig_len = 4*beats − st_empty of the eop beat.
  - pkt_end = min(orig_len, MAX_PKT_BYTES).
  - control[15:0] = orig_len, saturating at 16'hFFFF.
- ISSUE, exactly one cycle:
  - wr_ctrl=1.
  - control, pkt_begin, pkt_end, write_address are valid and stable from this cycle until wr_ctrl_rdy is seen.
  - Go to WAIT_RDY.
- WAIT_RDY: st_ready=0.
  - On wr_ctrl_rdy: compute rec = 16 + ((pkt_end+15) & ~15).
  - Next address = addr + rec. If that next address + 16 + MAX_PKT_BYTES > BUF_BASE+BUF_SIZE, next address = BUF_BASE instead.
  - Return to IDLE.
  - A wr_ctrl_rdy pulse outside WAIT_RDY is ignored.
- The FIFO is never written when fifo_usedw ≥ FIFO_DEPTH-2. Backpressure is used instead; no data loss in CAPTURE.
- Asynchronous reset mid-frame: FSM returns to IDLE and the address returns to BUF_BASE. FIFO flush is the owner's responsibility.

Optional Feature:
PKT_TRUNC_CNT_EN
- Defined: adds output trunc_cnt[15:0] (reset 0). It increments once per frame that enters SKIP or is terminated by a sop, and saturates at 16'hFFFF.
- Not defined: the port is absent and no counter logic is present.

Test Plan:
- 64-byte frame (16 beats, st_empty=0) at seconds=5, ns=100 -> 16 FIFO writes; one wr_ctrl pulse; pkt_end=64; write_address=BUF_BASE; ts_seconds=5, ts_nanoseconds=100.
- 61-byte frame (st_empty=3), then wr_ctrl_rdy -> pkt_end=61; next write_address = BUF_BASE+80.
- 2000-byte frame -> 384 FIFO writes; pkt_end=1536; control=32'h8000_07D0; st_ready stays 1 through the skipped tail; with PKT_TRUNC_CNT_EN, trunc_cnt=1.
- fifo_usedw held at 510 during CAPTURE -> st_ready=0 and no fifo_wrreq. Release -> capture resumes with no lost beat.
- Ring wrap with BUF_SIZE=4096: records advance until addr+1552 > BUF_BASE+4096 -> next write_address=BUF_BASE.
- Second frame arriving before wr_ctrl_rdy -> st_ready=0 throughout WAIT_RDY. Async reset asserted in CAPTURE -> all outputs 0 in the same cycle; next sop is captured at BUF_BASE.
